// File: rtl/pool_serialiser_if.sv
// Bundle of the pool_serialiser handshake signals: the wide capture side
// from the pooling layer and the single-word stream to the dense stage.
interface pool_serialiser_if #(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_POOLS  = 32
);
    localparam int IDX_WIDTH = (NUM_POOLS > 1) ? $clog2(NUM_POOLS) : 1;

    logic                  pool_serialiser_ready_in;
    logic [NUM_POOLS-1:0]  pool_serialiser_valid_in;
    logic [DATA_WIDTH-1:0] pool_serialiser_data_in [0:NUM_POOLS-1];
    logic                  pool_serialiser_ready_out;
    logic                  pool_serialiser_valid_out;
    logic [DATA_WIDTH-1:0] pool_serialiser_data_out;
    logic [IDX_WIDTH-1:0]  pool_serialiser_index_out;
    logic                  pool_serialiser_last_out;

    // View of the serialiser itself
    modport slave (
        output pool_serialiser_ready_in,
        input  pool_serialiser_valid_in,
        input  pool_serialiser_data_in,
        input  pool_serialiser_ready_out,
        output pool_serialiser_valid_out,
        output pool_serialiser_data_out,
        output pool_serialiser_index_out,
        output pool_serialiser_last_out
    );

    // View of the surrounding logic (pooling layer plus downstream consumer)
    modport master (
        input  pool_serialiser_ready_in,
        output pool_serialiser_valid_in,
        output pool_serialiser_data_in,
        output pool_serialiser_ready_out,
        input  pool_serialiser_valid_out,
        input  pool_serialiser_data_out,
        input  pool_serialiser_index_out,
        input  pool_serialiser_last_out
    );
endinterface

// File: rtl/pool_serialiser.sv
// pool_serialiser: captures one NUM_POOLS-wide pooled vector and replays it
// as a single-word valid/ready stream, channel 0 first, tagged with the
// channel index and a last-beat flag.
//
// Optional build macro POOL_SERIALISER_BACK_TO_BACK_EN: accept the next
// vector on the final beat of the current one, removing the idle bubble.
//
// state | meaning
// IDLE  | waiting for a fully valid vector, ready_in high
// SEND  | replaying buffer[idx] downstream, valid_out high
module pool_serialiser #(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_POOLS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    pool_serialiser_if.slave  bus
);
    localparam int IDX_WIDTH = (NUM_POOLS > 1) ? $clog2(NUM_POOLS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_POOLS - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                state, state_next;
    logic [IDX_WIDTH-1:0]  idx, idx_next;
    logic [DATA_WIDTH-1:0] buffer [NUM_POOLS];
    logic [DATA_WIDTH-1:0] data_sel;
    logic                  is_last;
    logic                  beat;
    logic                  ready_in;
    logic                  capture;

    // With a single channel the index carries no information, so select entry 0 directly
    generate
        if (NUM_POOLS == 1) begin : g_sel_single
            assign data_sel = buffer[0];
        end else begin : g_sel_multi
            assign data_sel = buffer[idx];
        end
    endgenerate

    // Handshake qualifiers and registered/buffered outputs
    always_comb begin
        is_last = (state == SEND) && (idx == LAST_IDX);
        beat    = (state == SEND) && bus.pool_serialiser_ready_out;
`ifdef POOL_SERIALISER_BACK_TO_BACK_EN
        ready_in = (state == IDLE) || (is_last && bus.pool_serialiser_ready_out);
`else
        ready_in = (state == IDLE);
`endif
        capture = ready_in && (&bus.pool_serialiser_valid_in);

        bus.pool_serialiser_ready_in  = ready_in;
        bus.pool_serialiser_valid_out = (state == SEND);
        bus.pool_serialiser_data_out  = (state == SEND) ? data_sel : '0;
        bus.pool_serialiser_index_out = idx;
        bus.pool_serialiser_last_out  = is_last;
    end

    // Next state and channel index
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = SEND;
                    idx_next   = '0;
                end
            end
            SEND: begin
                if (beat) begin
                    if (is_last) begin
                        idx_next   = '0;
                        state_next = capture ? SEND : IDLE;
                    end else begin
                        idx_next = idx + IDX_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // State and index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Vector buffer, loaded only on a full-vector capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_POOLS; i++) begin
                buffer[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_POOLS; i++) begin
                buffer[i] <= bus.pool_serialiser_data_in[i];
            end
        end
    end
endmodule

// File: tb/tb_pool_serialiser.sv
// Testbench for pool_serialiser: directed scenarios plus randomized traffic,
// checked against a queue-of-beats reference model.
module tb_pool_serialiser;
    localparam int DW = 12;
    localparam int NP = 4;
`ifdef POOL_SERIALISER_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pool_serialiser_if #(.DATA_WIDTH(DW), .NUM_POOLS(NP)) bus ();
    pool_serialiser_if #(.DATA_WIDTH(DW), .NUM_POOLS(1))  bus1 ();

    pool_serialiser #(.DATA_WIDTH(DW), .NUM_POOLS(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    pool_serialiser #(.DATA_WIDTH(DW), .NUM_POOLS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct {
        logic [DW-1:0] d;
        int            idx;
    } beat_t;

    beat_t         q[$];
    logic [DW-1:0] drv_data [NP];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model
    task automatic step(input logic [NP-1:0] v, input logic ro);
        bit exp_rin;
        bit beat;
        bit capt;
        @(negedge clk);
        bus.pool_serialiser_valid_in  = v;
        bus.pool_serialiser_ready_out = ro;
        for (int i = 0; i < NP; i++) bus.pool_serialiser_data_in[i] = drv_data[i];
        #1;
        exp_rin = (q.size() == 0) || (B2B && q.size() == 1 && ro);
        check("ready_in", 32'(bus.pool_serialiser_ready_in), 32'(exp_rin));
        check("valid_out", 32'(bus.pool_serialiser_valid_out), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("data_out", 32'(bus.pool_serialiser_data_out), 32'(q[0].d));
            check("index_out", 32'(bus.pool_serialiser_index_out), 32'(q[0].idx));
            check("last_out", 32'(bus.pool_serialiser_last_out), 32'(q[0].idx == NP - 1));
        end else begin
            check("last_idle", 32'(bus.pool_serialiser_last_out), 32'd0);
        end
        beat = (q.size() != 0) && ro;
        capt = exp_rin && (&v);
        if (beat) void'(q.pop_front());
        if (capt) begin
            for (int i = 0; i < NP; i++) begin
                beat_t b;
                b.d   = drv_data[i];
                b.idx = i;
                q.push_back(b);
            end
        end
    endtask

    task automatic set_vec(input int a, input int b, input int c, input int d);
        drv_data[0] = DW'(a);
        drv_data[1] = DW'(b);
        drv_data[2] = DW'(c);
        drv_data[3] = DW'(d);
    endtask

    initial begin
        bus.pool_serialiser_valid_in   = '0;
        bus.pool_serialiser_ready_out  = 1'b0;
        bus1.pool_serialiser_valid_in  = '0;
        bus1.pool_serialiser_ready_out = 1'b0;
        bus1.pool_serialiser_data_in[0] = '0;
        for (int i = 0; i < NP; i++) begin
            bus.pool_serialiser_data_in[i] = '0;
            drv_data[i] = '0;
        end

        // Reset values
        #12;
        check("rst_valid_out", 32'(bus.pool_serialiser_valid_out), 32'd0);
        check("rst_data_out", 32'(bus.pool_serialiser_data_out), 32'd0);
        check("rst_index_out", 32'(bus.pool_serialiser_index_out), 32'd0);
        check("rst_last_out", 32'(bus.pool_serialiser_last_out), 32'd0);
        check("rst_ready_in", 32'(bus.pool_serialiser_ready_in), 32'd1);
        check("rst1_ready_in", 32'(bus1.pool_serialiser_ready_in), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Single-channel instance: one beat, index 0, last high
        @(negedge clk);
        bus1.pool_serialiser_valid_in   = 1'b1;
        bus1.pool_serialiser_data_in[0] = 12'hFFF;
        bus1.pool_serialiser_ready_out  = 1'b1;
        #1;
        check("np1_ready_in", 32'(bus1.pool_serialiser_ready_in), 32'd1);
        @(negedge clk);
        bus1.pool_serialiser_valid_in = 1'b0;
        #1;
        check("np1_valid_out", 32'(bus1.pool_serialiser_valid_out), 32'd1);
        check("np1_data_out", 32'(bus1.pool_serialiser_data_out), 32'hFFF);
        check("np1_index_out", 32'(bus1.pool_serialiser_index_out), 32'd0);
        check("np1_last_out", 32'(bus1.pool_serialiser_last_out), 32'd1);
        @(negedge clk);
        #1;
        check("np1_done", 32'(bus1.pool_serialiser_valid_out), 32'd0);

        // Basic vector with ready_out high
        set_vec(10, 20, 30, 40);
        step(4'hF, 1'b1);
        repeat (5) step(4'h0, 1'b1);

        // Partial valid is ignored, then full valid captures
        repeat (5) step(4'b1011, 1'b1);
        step(4'hF, 1'b1);
        repeat (5) step(4'h0, 1'b1);

        // Backpressure while index 2 is presented
        step(4'hF, 1'b1);
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);
        repeat (3) step(4'h0, 1'b0);
        repeat (3) step(4'h0, 1'b1);

        // Consecutive vectors with valid_in held high
        set_vec(1, 2, 3, 4);
        step(4'hF, 1'b1);
        set_vec(5, 6, 7, 8);
        repeat (9) step(4'hF, 1'b1);
        repeat (6) step(4'h0, 1'b1);

        // Reset while index 1 is presented
        set_vec(11, 12, 13, 14);
        step(4'hF, 1'b1);
        step(4'h0, 1'b1);
        step(4'h0, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_valid_out", 32'(bus.pool_serialiser_valid_out), 32'd0);
        check("midrst_data_out", 32'(bus.pool_serialiser_data_out), 32'd0);
        check("midrst_ready_in", 32'(bus.pool_serialiser_ready_in), 32'd1);
        check("midrst_index_out", 32'(bus.pool_serialiser_index_out), 32'd0);
        q.delete();
        #2;
        rst = 1'b1;
        set_vec(21, 22, 23, 24);
        step(4'hF, 1'b1);
        repeat (5) step(4'h0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [NP-1:0] v;
            for (int i = 0; i < NP; i++) drv_data[i] = DW'($urandom_range(0, 4095));
            v = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            step(v, ($urandom_range(0, 3) != 0));
        end
        repeat (40) step(4'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pool_serialiser.md
Name: pool_serialiser

Overview:
- Consumer side of the global-average-pool layer's parallel output.
- Accepts one NUM_POOLS-wide vector, one word per channel, in a single handshake.
- Replays it as a single-word valid/ready stream, channel 0 first, for the downstream dense/classifier stage.
- Adds channel index and last-beat tags so the consumer can frame each vector.

Parameters:
- DATA_WIDTH, 12, width of each channel word.
- NUM_POOLS, 32, channels per vector; legal range 1 or more.
- IDX_WIDTH, $clog2(NUM_POOLS) with a minimum of 1, width of the index output. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- pool_serialiser_ready_in  output  1  block can capture a vector this cycle.
- pool_serialiser_valid_in  input  NUM_POOLS  per-channel valid from the pooling layer.
- pool_serialiser_data_in  input  DATA_WIDTH x [0:NUM_POOLS-1]  unpacked per-channel words.
- pool_serialiser_ready_out  input  1  downstream accepts a word.
- pool_serialiser_valid_out  output  1  data_out holds a valid word.
- pool_serialiser_data_out  output  DATA_WIDTH  current channel word.
- pool_serialiser_index_out  output  IDX_WIDTH  channel number of the current word.
- pool_serialiser_last_out  output  1  current word is channel NUM_POOLS-1.

Behaviour:
- Reset (rst low, asynchronous):
  - state goes to IDLE; idx = 0; buffer cleared to 0.
  - valid_out = 0, data_out = 0, index_out = 0, last_out = 0, ready_in = 1.
  - Reset mid-vector abandons the vector; no further words are emitted.
- States: IDLE and SEND, two-state FSM.
- IDLE:
  - ready_in = 1, valid_out = 0.
  - Capture fires when ready_in is high and the AND of all valid_in bits is high.
  - On capture: register all NUM_POOLS words into the buffer, set idx = 0, go to SEND.
  - Partial valid (some bits low): nothing is captured and the state does not change. Partially valid words are never latched.
- SEND:
  - ready_in = 0 (unless the optional feature is enabled).
  - valid_out = 1, data_out = buffer[idx], index_out = idx, last_out = 1 when idx == NUM_POOLS-1.
  - A beat transfers when valid_out and ready_out are both high. On a beat: if last, go to IDLE and clear idx to 0; otherwise idx increments by 1.
  - When ready_out is low: data_out, index_out and last_out hold stable and valid_out stays high. There is no retraction.
- Latency and throughput:
  - First valid_out is asserted the cycle after capture.
  - With ready_out tied high, NUM_POOLS beats are output on consecutive cycles.
  - Vector period is NUM_POOLS + 1 cycles (one IDLE cycle between vectors).
- Width and arithmetic:
  - Data passes through unmodified, with no sign extension or rounding.
  - idx never exceeds NUM_POOLS-1; there is no wrap past that value.
- Outputs: data_out, index_out and last_out are driven from registers or the buffer mux, with no combinational path from the data inputs.
- NUM_POOLS = 1: SEND lasts one beat, last_out = 1 whenever valid_out = 1, index_out = 0.
- Buffer contents outside SEND are don't-care, but data_out must read 0 after reset.

Optional Feature:
- Macro: POOL_SERIALISER_BACK_TO_BACK_EN.
- When defined:
  - ready_in is also high in SEND when last_out and ready_out are both high.
  - A capture in that cycle reloads the buffer, sets idx = 0, and stays in SEND.
  - Result: zero bubble between vectors and a vector period of NUM_POOLS cycles.
  - This adds a combinational path from ready_out to ready_in, which is accepted.
- When undefined: ready_in is a function of state only, and the vector period is NUM_POOLS + 1.

Test Plan:
- Reset release with NUM_POOLS=4, valid_in=4'b1111, data {10,20,30,40}, ready_out=1 -> data_out 10,20,30,40 on 4 consecutive cycles starting 1 cycle after capture; index 0..3; last_out high only with 40; ready_in low for those 4 cycles.
- Partial valid: valid_in=4'b1011 held 5 cycles -> ready_in stays 1, valid_out stays 0; then 4'b1111 -> capture occurs.
- Backpressure: ready_out low for 3 cycles during index 2 -> data_out=30 and index_out=2 held stable with valid_out=1; resumes with 40 after ready_out rises.
- Reset asserted while index_out=1 -> valid_out=0, data_out=0, ready_in=1 immediately; the next vector starts at index 0.
- Back-to-back, macro defined: two vectors {1,2,3,4} and {5,6,7,8} with ready_out=1 -> 8 consecutive beats with no gap. Macro undefined -> a one-cycle valid_out=0 gap after 4.
- NUM_POOLS=1, data 12'hFFF -> single beat: data_out=12'hFFF, index_out=0, last_out=1.
